ext_mem_arbiter: RTL and testbench
==================================

# ext_mem_arbiter

Round-robin arbiter that shares one native-bus slave port, normally the external-memory data port, among N native-bus masters such as the CPU data bus and a DMA or accelerator engine. It holds the grant for one complete transaction, from the slave request until `ready`. It then rotates priority, with no idle cycle between back-to-back transactions. It sits between the masters and `ext_mem`, in place of a direct connection.

## Interface
- `N_MASTERS`, default 2: number of requesting masters (≥2).
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 32: data width; `wstrb` is `DATA_W/8` bits.
- Derived widths:
  - `REQ_W` = 1+ADDR_W+DATA_W+DATA_W/8, packed as {valid, addr, wdata, wstrb}, MSB first.
  - `RESP_W` = DATA_W+1, packed as {rdata, ready}.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `m_req`  in  N_MASTERS*REQ_W  master requests; master i occupies `[(i+1)*REQ_W-1 : i*REQ_W]`.
- `m_resp`  out  N_MASTERS*RESP_W  master responses, packed the same way.
- `s_req`  out  REQ_W  request to the shared slave.
- `s_resp`  in  RESP_W  response from the shared slave.
- `grant`  out  N_MASTERS  one-hot registered grant; all zero when idle.

## Operation
- **Bus protocol.** A master raises `valid` and holds addr/wdata/wstrb until it sees `ready` high for one cycle. `wstrb==0` means a read. `rdata` is valid only in the `ready` cycle.
- **States:**
  - IDLE: `grant`=0, `s_req.valid`=0.
  - BUSY: exactly one `grant` bit set.
- **Arbitration** (combinational sub-module):
  - Rotating search starts at pointer `ptr` and picks the first master with `valid`=1.
  - Index arithmetic is mod N_MASTERS; `ptr` is ceil(log2 N) bits.
- **IDLE → BUSY:** when any valid master is found, register `grant` to that master.
- **In BUSY:**
  - `s_req` = `m_req` of the granted master, passed through combinationally.
  - Granted master's `m_resp` = `s_resp` (rdata and ready).
  - Every other master's `m_resp` = 0, so `ready`=0 and `rdata`=0.
- **Completion** (`s_resp.ready`=1 in BUSY):
  - `ptr` ← granted+1 mod N.
  - Re-arbitrate in the same cycle using the new `ptr`, excluding the just-finished master (its `valid` belongs to the completed transaction).
  - If another master is found: stay BUSY with the new grant next cycle.
  - If none is found: go to IDLE.
  - The just-finished master can win again from the next cycle onward.
- **Grant hold:** the grant is never withdrawn before `ready`. A granted master that drops `valid` before `ready` is a protocol violation. The arbiter keeps the grant, `s_req.valid` follows the master, and there is no recovery except reset.
- **`ready` while IDLE:** a `ready` seen while IDLE is ignored and is not routed to any master.

## Timing
- **Reset values:**
  - Async reset forces IDLE, `grant`=0, `ptr`=0 immediately.
  - As a result, `s_req.valid`=0 and all `m_resp`=0, even mid-transaction.
  - An outstanding slave transaction is abandoned; the slave is reset by the same `rst`.
- **Arbitration latency:** a master's `valid` rising in cycle t while IDLE → `grant` and `s_req.valid` high in t+1.
- **Response latency:** zero added cycles. `s_resp.ready` in cycle k appears on the granted `m_resp` in k.
- **Back-to-back:** a waiting master is granted in k+1, giving 0 bubbles between transactions.
- **Simultaneous requests:** with all masters requesting continuously, grants cycle 0,1,…,N-1,0 with one transaction each. The starvation bound is N-1 transactions.
- **Single-cycle slave:** `ready` in the same cycle as `s_req.valid` is supported; each transaction then occupies one BUSY cycle.

## Structure
- **Shared header (`interconnect.vh`):** REQ_W/RESP_W definitions and field offsets (valid, addr, wdata, wstrb, rdata, ready). These are reused with the existing split logic.
- **Sub-module `rr_pick`:**
  - Parameter N.
  - Inputs: `req[N]`, `ptr`, `mask[N]`.
  - Output: one-hot `sel[N]` plus `any`.
  - Purely combinational rotating priority encoder.
- **Top level:** state register, `ptr` register, grant register and the mux/demux of the packed buses.

## Test plan
- **Single read:** master 0 reads addr 0x100; the slave answers `ready` 3 cycles later with rdata 0xDEADBEEF → `grant`=01 one cycle after valid; master 0 gets rdata in the `ready` cycle; master 1's `m_resp`=0 throughout.
- **Contention:** both masters hold valid from cycle 0 with a 1-cycle slave → grant sequence 01, 10, 01, 10 with no IDLE cycles between transactions.
- **Write pass-through:** master 1 writes 0xCAFEF00D with wstrb 0xF while master 0 is idle → `s_req` equals master 1's request bit-exactly; master 1's `ready` coincides with `s_resp.ready`.
- **Fairness with N_MASTERS=3:** master 2 requests continuously; masters 0 and 1 request sporadically → master 2 waits at most 2 transactions each time.
- **Reset mid-transaction:** `rst` is pulsed while BUSY → `grant`=0 and `s_req.valid`=0 in the same cycle. After release, the first grant goes to the lowest-index valid master (`ptr`=0).
- **Stray ready:** `s_resp.ready` is pulsed while IDLE → no master sees `ready`; state stays IDLE.

Source files
------------

// File: rtl/ext_mem_arbiter_pkg.sv
// ext_mem_arbiter_pkg: shared state type and bus width helpers for the external-memory arbiter
package ext_mem_arbiter_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Request packing is {valid, addr, wdata, wstrb}, MSB first
    function automatic int req_width(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    // Response packing is {rdata, ready}
    function automatic int resp_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/ext_mem_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder, first eligible requester at or after ptr
module rr_pick
    import ext_mem_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  sel,
    output logic          any
);

    logic [N-1:0] elig;
    logic [PW:0]  s;

    assign elig = req & ~mask;

    // Walk offsets from farthest to nearest so the closest eligible index wins
    always_comb begin
        sel = '0;
        any = 1'b0;
        s   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (PW + 1)'(k);
            if (s >= (PW + 1)'(N)) s = s - (PW + 1)'(N);
            if (elig[s[PW-1:0]]) begin
                sel = '0;
                sel[s[PW-1:0]] = 1'b1;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: round-robin arbiter sharing one native-bus slave port among N masters,
// holding the grant for a whole transaction and rotating priority on each completion.
module ext_mem_arbiter
    import ext_mem_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int REQ_W    = req_width(ADDR_W, DATA_W),
    localparam int RESP_W   = resp_width(DATA_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          grant
);

    localparam int PW = ptr_width(N_MASTERS);

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d, valid, sel, pick_mask;
    logic [PW-1:0]        ptr_q, ptr_d, g_idx, g_next, pick_ptr;
    logic [PW:0]          g_inc;
    logic                 any, ready;

    assign ready = s_resp[0];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
        assign valid[i] = m_req[i*REQ_W + REQ_W - 1];
        assign m_resp[i*RESP_W +: RESP_W] = grant_q[i] ? s_resp : '0;
    end

    // Grant is one-hot or zero, so an OR-reduction acts as both mux and encoder
    always_comb begin
        g_idx = '0;
        s_req = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            g_idx |= grant_q[i] ? PW'(i) : '0;
            s_req |= grant_q[i] ? m_req[i*REQ_W +: REQ_W] : '0;
        end
    end

    assign g_inc  = {1'b0, g_idx} + (PW + 1)'(1);
    assign g_next = (g_inc == (PW + 1)'(N_MASTERS)) ? '0 : g_inc[PW-1:0];

    // While busy the picker only matters on completion: search from granted+1, skipping the finisher
    assign pick_ptr  = (state_q == BUSY) ? g_next : ptr_q;
    assign pick_mask = (state_q == BUSY) ? grant_q : '0;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req  (valid),
        .ptr  (pick_ptr),
        .mask (pick_mask),
        .sel  (sel),
        .any  (any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE || ready) begin
            state_d = any ? BUSY : IDLE;
            grant_d = sel;
        end
        if (state_q == BUSY && ready) ptr_d = g_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed checks of grant timing, pass-through, rotation, reset and stray ready
module tb_ext_mem_arbiter;

    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic                clk = 1'b0;
    logic                rst;
    logic [2*REQ_W-1:0]  m_req;
    logic [2*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]    s_req;
    logic [RESP_W-1:0]   s_resp;
    logic [1:0]          grant;

    logic [3*REQ_W-1:0]  m_req3;
    logic [3*RESP_W-1:0] m_resp3;
    logic [REQ_W-1:0]    s_req3;
    logic [RESP_W-1:0]   s_resp3;
    logic [2:0]          grant3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] fv [9] = '{3'b111, 3'b110, 3'b101, 3'b111, 3'b110, 3'b100, 3'b100, 3'b100, 3'b000};
    logic [2:0] fg [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b100, 3'b000};

    always #5 clk = ~clk;

    ext_mem_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .grant(grant)
    );

    ext_mem_arbiter #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32)) dut3 (
        .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3),
        .s_req(s_req3), .s_resp(s_resp3), .grant(grant3)
    );

    function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [31:0] a,
                                                input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set3(input logic [2:0] v);
        for (int i = 0; i < 3; i++)
            m_req3[i*REQ_W +: REQ_W] = mk_req(v[i], 32'h1000 + 32'(i), 32'h0, 4'h0);
    endtask

    initial begin
        rst = 1'b1; m_req = '0; s_resp = '0; m_req3 = '0; s_resp3 = '0;
        #1;
        chk("rst_grant", 128'(grant), 128'h0);
        chk("rst_s_req", 128'(s_req), 128'h0);
        chk("rst_m_resp", 128'(m_resp), 128'h0);
        chk("rst_grant3", 128'(grant3), 128'h0);
        step(); step();
        rst = 1'b0;
        step();

        // single read by master 0, slave answers after a few cycles
        m_req[0 +: REQ_W] = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
        #1;
        chk("read_t_idle", 128'(grant), 128'h0);
        step();
        chk("read_grant", 128'(grant), 128'h1);
        chk("read_s_req", 128'(s_req), 128'(mk_req(1'b1, 32'h100, 32'h0, 4'h0)));
        chk("read_m1_wait", 128'(m_resp[RESP_W +: RESP_W]), 128'h0);
        step(); step();
        chk("read_hold", 128'(grant), 128'h1);
        s_resp = {32'hDEADBEEF, 1'b1};
        #1;
        chk("read_m0_resp", 128'(m_resp[0 +: RESP_W]), 128'({32'hDEADBEEF, 1'b1}));
        chk("read_m1_resp", 128'(m_resp[RESP_W +: RESP_W]), 128'h0);
        step();
        m_req = '0; s_resp = '0;
        #1;
        chk("read_idle", 128'(grant), 128'h0);

        // stray ready while idle
        s_resp = {32'h12345678, 1'b1};
        #1;
        chk("stray_m_resp", 128'(m_resp), 128'h0);
        step();
        chk("stray_grant", 128'(grant), 128'h0);
        chk("stray_s_req", 128'(s_req), 128'h0);
        s_resp = '0;

        // write pass-through from master 1
        m_req[REQ_W +: REQ_W] = mk_req(1'b1, 32'h200, 32'hCAFEF00D, 4'hF);
        step();
        chk("wr_grant", 128'(grant), 128'h2);
        chk("wr_s_req", 128'(s_req), 128'(mk_req(1'b1, 32'h200, 32'hCAFEF00D, 4'hF)));
        s_resp = 33'h1;
        #1;
        chk("wr_m1_ready", 128'(m_resp[RESP_W +: RESP_W]), 128'h1);
        chk("wr_m0_resp", 128'(m_resp[0 +: RESP_W]), 128'h0);
        step();
        m_req = '0; s_resp = '0;
        #1;
        chk("wr_idle", 128'(grant), 128'h0);

        // single-cycle transaction by master 0 moves the pointer to 1
        m_req[0 +: REQ_W] = mk_req(1'b1, 32'h300, 32'h0, 4'h0);
        step();
        chk("sc_grant", 128'(grant), 128'h1);
        s_resp = 33'h1;
        step();
        chk("sc_idle", 128'(grant), 128'h0);
        s_resp = '0;

        // reset pulsed mid-transaction
        m_req[0 +: REQ_W] = mk_req(1'b1, 32'h400, 32'h0, 4'h0);
        step();
        chk("pre_rst_grant", 128'(grant), 128'h1);
        rst = 1'b1; s_resp = 33'h1;
        #1;
        chk("mid_rst_grant", 128'(grant), 128'h0);
        chk("mid_rst_s_req", 128'(s_req), 128'h0);
        chk("mid_rst_m_resp", 128'(m_resp), 128'h0);
        step();
        rst = 1'b0;
        m_req = {mk_req(1'b1, 32'h500, 32'h0, 4'h0), mk_req(1'b1, 32'h600, 32'h0, 4'h0)};

        // contention with a single-cycle slave, pointer back at 0
        step();
        chk("cont_g1", 128'(grant), 128'h1);
        chk("cont_r1", 128'({m_resp[RESP_W], m_resp[0]}), 128'h1);
        step();
        chk("cont_g2", 128'(grant), 128'h2);
        chk("cont_r2", 128'({m_resp[RESP_W], m_resp[0]}), 128'h2);
        step();
        chk("cont_g3", 128'(grant), 128'h1);
        step();
        chk("cont_g4", 128'(grant), 128'h2);
        m_req = '0;
        step();
        chk("cont_idle", 128'(grant), 128'h0);
        s_resp = '0;

        // fairness on three masters with a single-cycle slave
        s_resp3 = 33'h1;
        for (int i = 0; i < 9; i++) begin
            set3(fv[i]);
            step();
            chk($sformatf("fair_g%0d", i + 1), 128'(grant3), 128'(fg[i]));
        end
        s_resp3 = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
